// File: rtl/lockin_param_core_if.sv
// Bus bundle for lockin_param_core: config, streaming sample/ROM handshake and results.
interface lockin_param_core_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REF_W  = 16,
  parameter int unsigned ACC_W  = 64,
  parameter int unsigned IDX_W  = 16
);
  logic                     enable;
  logic                     cfg_load;
  logic [IDX_W-1:0]         cfg_ptos_x_ciclo;
  logic [15:0]              cfg_frames;
  logic                     cfg_continuous;
  logic                     start;
  logic signed [DATA_W-1:0] data_in;
  logic                     data_in_valid;
  logic [IDX_W-1:0]         ref_idx;
  logic signed [REF_W-1:0]  ref_sin;
  logic signed [REF_W-1:0]  ref_cos;
  logic signed [ACC_W-1:0]  data_out_fase;
  logic signed [ACC_W-1:0]  data_out_cuad;
  logic                     data_out_valid;
  logic                     lockin_ready;
  logic                     calc_finished;
  logic                     sat_flag;

  modport slave (
    input  enable, cfg_load, cfg_ptos_x_ciclo, cfg_frames, cfg_continuous, start,
           data_in, data_in_valid, ref_sin, ref_cos,
    output ref_idx, data_out_fase, data_out_cuad, data_out_valid,
           lockin_ready, calc_finished, sat_flag
  );

  modport master (
    output enable, cfg_load, cfg_ptos_x_ciclo, cfg_frames, cfg_continuous, start,
           data_in, data_in_valid, ref_sin, ref_cos,
    input  ref_idx, data_out_fase, data_out_cuad, data_out_valid,
           lockin_ready, calc_finished, sat_flag
  );
endinterface

// File: rtl/lockin_param_core.sv
// Dual-phase lock-in core: sample x ROM sin/cos, integrated over N cycles of M points.
// Optional macro LOCKIN_SAT_EN selects saturating accumulation (default: wrap, sat_flag=0).
module lockin_param_core #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REF_W  = 16,
  parameter int unsigned ACC_W  = 64,
  parameter int unsigned IDX_W  = 16
) (
  input logic              clk,
  input logic              reset_n,
  lockin_param_core_if.slave bus
);
  localparam int unsigned PROD_W = DATA_W + REF_W;
  localparam int unsigned SUM_W  = ACC_W + 1;
  localparam int unsigned FRM_W  = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  m_q, m_d, pt_cnt_q, pt_cnt_d;
  logic [FRM_W-1:0]  n_q, n_d, cyc_cnt_q, cyc_cnt_d;
  logic              cont_q, cont_d;
  logic              ready_q, ready_d, fin_q, fin_d, sat_q, sat_d;
  logic              cfg_ok_c, accept_c, pt_wrap_c, last_c, cfg_clr_c;

  logic                     s1_vld_q, s1_last_q, s2_vld_q, s2_last_q, p_vld_q, p_last_q;
  logic signed [DATA_W-1:0] s1_data_q, s1_data_d, s2_data_q;
  logic signed [REF_W-1:0]  s2_sin_q, s2_cos_q;
  logic signed [PROD_W-1:0] p_sin_q, p_cos_q, mul_sin_c, mul_cos_c;
  logic signed [ACC_W-1:0]  acc_sin_q, acc_sin_d, acc_cos_q, acc_cos_d;
  logic signed [ACC_W-1:0]  out_fase_q, out_fase_d, out_cuad_q, out_cuad_d;
  logic                     out_vld_q, out_vld_d;
  logic [ACC_W:0]           r_sin_c, r_cos_c;

  // Returns {overflow, sum}; overflow only ever reported when saturation is built in.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
`ifdef LOCKIN_SAT_EN
    if (s[ACC_W] != s[ACC_W-1]) return {1'b1, (s[ACC_W] ? ACC_MIN : ACC_MAX)};
`endif
    return {1'b0, s[ACC_W-1:0]};
  endfunction

  assign cfg_ok_c  = (m_q != '0) && (n_q != '0);
  assign accept_c  = (state_q == ST_RUN) && bus.enable && bus.data_in_valid;
  assign pt_wrap_c = (pt_cnt_q == m_q - IDX_W'(1));
  assign last_c    = accept_c && pt_wrap_c && (cyc_cnt_q == n_q - FRM_W'(1));

  // Control FSM, point/cycle counters and config registers.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    n_d       = n_q;
    cont_d    = cont_q;
    pt_cnt_d  = pt_cnt_q;
    cyc_cnt_d = cyc_cnt_q;
    cfg_clr_c = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.cfg_load) begin
          m_d       = bus.cfg_ptos_x_ciclo;
          n_d       = bus.cfg_frames;
          cont_d    = bus.cfg_continuous;
          cfg_clr_c = 1'b1;
          state_d   = ST_IDLE;
        end else if (bus.start && cfg_ok_c) begin
          pt_cnt_d  = '0;
          cyc_cnt_d = '0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept_c) begin
          if (pt_wrap_c) begin
            pt_cnt_d  = '0;
            cyc_cnt_d = last_c ? '0 : cyc_cnt_q + FRM_W'(1);
          end else begin
            pt_cnt_d  = pt_cnt_q + IDX_W'(1);
          end
          if (last_c && !cont_q) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE) && (m_d != '0) && (n_d != '0);
    fin_d   = (state_d == ST_DONE) && (fin_q || (p_vld_q && p_last_q));
  end

  assign s1_data_d = accept_c ? bus.data_in : s1_data_q;
  assign mul_sin_c = PROD_W'(s2_data_q) * PROD_W'(s2_sin_q);
  assign mul_cos_c = PROD_W'(s2_data_q) * PROD_W'(s2_cos_q);

  // Accumulate stage; the last sample of a window emits and zeroes the accumulators,
  // so they are already clear whenever a new window starts.
  always_comb begin
    acc_sin_d  = acc_sin_q;
    acc_cos_d  = acc_cos_q;
    out_fase_d = out_fase_q;
    out_cuad_d = out_cuad_q;
    out_vld_d  = 1'b0;
    sat_d      = cfg_clr_c ? 1'b0 : sat_q;
    r_sin_c    = acc_add(acc_sin_q, ACC_W'(p_sin_q));
    r_cos_c    = acc_add(acc_cos_q, ACC_W'(p_cos_q));
    if (p_vld_q) begin
      if (r_sin_c[ACC_W] || r_cos_c[ACC_W]) sat_d = 1'b1;
      if (p_last_q) begin
        out_fase_d = r_sin_c[ACC_W-1:0];
        out_cuad_d = r_cos_c[ACC_W-1:0];
        out_vld_d  = 1'b1;
        acc_sin_d  = '0;
        acc_cos_d  = '0;
      end else begin
        acc_sin_d  = r_sin_c[ACC_W-1:0];
        acc_cos_d  = r_cos_c[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      m_q        <= '0;
      n_q        <= '0;
      cont_q     <= 1'b0;
      pt_cnt_q   <= '0;
      cyc_cnt_q  <= '0;
      ready_q    <= 1'b0;
      fin_q      <= 1'b0;
      sat_q      <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_data_q  <= '0;
      s2_vld_q   <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_data_q  <= '0;
      s2_sin_q   <= '0;
      s2_cos_q   <= '0;
      p_vld_q    <= 1'b0;
      p_last_q   <= 1'b0;
      p_sin_q    <= '0;
      p_cos_q    <= '0;
      acc_sin_q  <= '0;
      acc_cos_q  <= '0;
      out_fase_q <= '0;
      out_cuad_q <= '0;
      out_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      n_q        <= n_d;
      cont_q     <= cont_d;
      pt_cnt_q   <= pt_cnt_d;
      cyc_cnt_q  <= cyc_cnt_d;
      ready_q    <= ready_d;
      fin_q      <= fin_d;
      sat_q      <= sat_d;
      s1_vld_q   <= accept_c;
      s1_last_q  <= last_c;
      s1_data_q  <= s1_data_d;
      // ROM words for the sample held in s1 arrive one cycle after its index.
      s2_vld_q   <= s1_vld_q;
      s2_last_q  <= s1_last_q;
      s2_data_q  <= s1_data_q;
      s2_sin_q   <= bus.ref_sin;
      s2_cos_q   <= bus.ref_cos;
      p_vld_q    <= s2_vld_q;
      p_last_q   <= s2_last_q;
      p_sin_q    <= mul_sin_c;
      p_cos_q    <= mul_cos_c;
      acc_sin_q  <= acc_sin_d;
      acc_cos_q  <= acc_cos_d;
      out_fase_q <= out_fase_d;
      out_cuad_q <= out_cuad_d;
      out_vld_q  <= out_vld_d;
    end
  end

  assign bus.ref_idx        = pt_cnt_q;
  assign bus.data_out_fase  = out_fase_q;
  assign bus.data_out_cuad  = out_cuad_q;
  assign bus.data_out_valid = out_vld_q;
  assign bus.lockin_ready   = ready_q;
  assign bus.calc_finished  = fin_q;
`ifdef LOCKIN_SAT_EN
  assign bus.sat_flag       = sat_q;
`else
  assign bus.sat_flag       = 1'b0;
`endif
endmodule
